// File: rtl/melody_seq.sv
// Eight-note ROM sequencer driving the buzzer tone divider, LEDs and 7-segment note index.
// Optional feature: define MELODY_SEQ_TEMPO_EN to add the tempo[1:0] scaling input.
module melody_seq #(
    parameter int CLK_HZ    = 10_000_000,
    parameter int TICK_HZ   = 100,
    parameter int GAP_TICKS = 2,
    parameter int DW        = 26
) (
    input  logic          clk_out,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          loop,
`ifdef MELODY_SEQ_TEMPO_EN
    input  logic [1:0]    tempo,
`endif
    output logic          busy,
    output logic [DW-1:0] freqdiv,
    output logic          tone_en,
    output logic [2:0]    note_idx,
    output logic          note_strobe,
    output logic          done
);

    localparam int DIV = (CLK_HZ / TICK_HZ > 0) ? CLK_HZ / TICK_HZ : 1;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW  = 16;
    localparam int EW  = DW + 7;

    typedef enum logic [1:0] {IDLE, PLAY, GAP, DONE} state_t;

    // Entry layout: {freqdiv, dur[5:0], last}
    function automatic logic [EW-1:0] rom(input logic [2:0] idx);
        case (idx)
            3'd0:    rom = {DW'(9555), 6'd20, 1'b0};
            3'd1:    rom = {DW'(8512), 6'd20, 1'b0};
            3'd2:    rom = {DW'(7583), 6'd20, 1'b0};
            3'd3:    rom = {DW'(7158), 6'd20, 1'b0};
            3'd4:    rom = {DW'(6377), 6'd20, 1'b0};
            3'd5:    rom = {DW'(5681), 6'd20, 1'b0};
            3'd6:    rom = {DW'(5061), 6'd20, 1'b0};
            default: rom = {DW'(4777), 6'd40, 1'b1};
        endcase
    endfunction

    function automatic logic [DW-1:0] rom_freq(input logic [2:0] idx);
        return DW'(rom(idx) >> 7);
    endfunction

    function automatic logic [5:0] rom_dur(input logic [2:0] idx);
        return 6'(rom(idx) >> 1);
    endfunction

    function automatic logic rom_last(input logic [2:0] idx);
        return 1'(rom(idx));
    endfunction

    // tempo 1 doubles the tick count, tempo 2 halves it rounding up, never below one tick
    function automatic logic [TW-1:0] scale(input logic [TW-1:0] n, input logic [1:0] t);
        logic [TW-1:0] r;
        case (t)
            2'd1:    r = n << 1;
            2'd2:    r = (n + TW'(1)) >> 1;
            default: r = n;
        endcase
        if (r == '0) r = TW'(1);
        return r;
    endfunction

    state_t        state, state_d;
    logic [PW-1:0] presc, presc_d;
    logic [TW-1:0] tick, tick_d;
    logic [1:0]    tempo_q, tempo_d, tempo_in;
    logic [DW-1:0] freqdiv_d;
    logic          tone_d, strobe_d, done_d;
    logic [2:0]    idx_d, nxt_idx;
    logic          enter, note_end, go_idle, tick_end;
    logic [5:0]    cur_dur;
    logic [TW-1:0] play_ticks, gap_ticks;

`ifdef MELODY_SEQ_TEMPO_EN
    assign tempo_in = tempo;
`else
    assign tempo_in = 2'd0;
`endif

    assign busy       = (state != IDLE);
    assign cur_dur    = rom_dur(note_idx);
    assign play_ticks = scale((cur_dur == 6'd0) ? TW'(1) : TW'(cur_dur), tempo_q);
    assign gap_ticks  = scale(TW'(GAP_TICKS), tempo_q);

    always_ff @(posedge clk_out or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            presc       <= '0;
            tick        <= '0;
            tempo_q     <= 2'd0;
            freqdiv     <= '0;
            tone_en     <= 1'b0;
            note_idx    <= 3'd0;
            note_strobe <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_d;
            presc       <= presc_d;
            tick        <= tick_d;
            tempo_q     <= tempo_d;
            freqdiv     <= freqdiv_d;
            tone_en     <= tone_d;
            note_idx    <= idx_d;
            note_strobe <= strobe_d;
            done        <= done_d;
        end
    end

    always_comb begin
        state_d   = state;
        presc_d   = presc;
        tick_d    = tick;
        tempo_d   = tempo_q;
        freqdiv_d = freqdiv;
        tone_d    = tone_en;
        idx_d     = note_idx;
        strobe_d  = 1'b0;
        done_d    = 1'b0;
        enter     = 1'b0;
        nxt_idx   = 3'd0;
        note_end  = 1'b0;
        go_idle   = 1'b0;
        tick_end  = (presc == PW'(DIV - 1));

        case (state)
            IDLE: enter = start && !stop;
            PLAY: begin
                if (stop) begin
                    go_idle = 1'b1;
                end else if (tick_end) begin
                    presc_d = '0;
                    if (tick == play_ticks - TW'(1)) begin
                        tick_d = '0;
                        if (GAP_TICKS == 0) begin
                            note_end = 1'b1;
                        end else begin
                            state_d = GAP;
                            tone_d  = 1'b0;
                        end
                    end else begin
                        tick_d = tick + TW'(1);
                    end
                end else begin
                    presc_d = presc + PW'(1);
                end
            end
            GAP: begin
                if (stop) begin
                    go_idle = 1'b1;
                end else if (tick_end) begin
                    presc_d = '0;
                    if (tick == gap_ticks - TW'(1)) begin
                        tick_d   = '0;
                        note_end = 1'b1;
                    end else begin
                        tick_d = tick + TW'(1);
                    end
                end else begin
                    presc_d = presc + PW'(1);
                end
            end
            default: go_idle = 1'b1;
        endcase

        // Index 7 ends the song even if its last flag were clear; wrap happens only via loop
        if (note_end) begin
            if (!rom_last(note_idx) && note_idx != 3'd7) begin
                enter   = 1'b1;
                nxt_idx = note_idx + 3'd1;
            end else if (loop) begin
                enter = 1'b1;
            end else begin
                state_d   = DONE;
                done_d    = 1'b1;
                tone_d    = 1'b0;
                freqdiv_d = '0;
            end
        end

        if (enter) begin
            state_d   = PLAY;
            idx_d     = nxt_idx;
            freqdiv_d = rom_freq(nxt_idx);
            tone_d    = (rom_freq(nxt_idx) != '0);
            strobe_d  = 1'b1;
            presc_d   = '0;
            tick_d    = '0;
            tempo_d   = tempo_in;
        end

        if (go_idle) begin
            state_d   = IDLE;
            freqdiv_d = '0;
            tone_d    = 1'b0;
            idx_d     = 3'd0;
            presc_d   = '0;
            tick_d    = '0;
        end
    end

endmodule

// File: tb/tb_melody_seq.sv
// Randomised and directed bench for melody_seq against a cycle-countdown reference model.
// Builds with or without MELODY_SEQ_TEMPO_EN.
module tb_melody_seq;

    localparam int CLK_HZ    = 1000;
    localparam int TICK_HZ   = 100;
    localparam int GAP_TICKS = 2;
    localparam int DW        = 26;
    localparam int DIV       = CLK_HZ / TICK_HZ;
`ifdef MELODY_SEQ_TEMPO_EN
    localparam bit TEMPO_EN = 1'b1;
`else
    localparam bit TEMPO_EN = 1'b0;
`endif

    localparam int PH_IDLE = 0;
    localparam int PH_PLAY = 1;
    localparam int PH_GAP  = 2;
    localparam int PH_DONE = 3;

    logic          clk_out;
    logic          rst;
    logic          start, stop, loop;
    logic [1:0]    tempo;
    logic          busy, tone_en, note_strobe, done;
    logic [DW-1:0] freqdiv;
    logic [2:0]    note_idx;

    int rom_freq [8] = '{9555, 8512, 7583, 7158, 6377, 5681, 5061, 4777};
    int rom_dur  [8] = '{20, 20, 20, 20, 20, 20, 20, 40};
    int rom_last [8] = '{0, 0, 0, 0, 0, 0, 0, 1};

    int m_phase, m_left, m_idx, m_tempo;
    bit m_strobe;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_strobe, cnt_done, cnt_tone0, cnt_tone7;

    melody_seq #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .GAP_TICKS(GAP_TICKS), .DW(DW)
    ) dut (
        .clk_out(clk_out),
        .rst(rst),
        .start(start),
        .stop(stop),
        .loop(loop),
`ifdef MELODY_SEQ_TEMPO_EN
        .tempo(tempo),
`endif
        .busy(busy),
        .freqdiv(freqdiv),
        .tone_en(tone_en),
        .note_idx(note_idx),
        .note_strobe(note_strobe),
        .done(done)
    );

    initial clk_out = 1'b0;
    always #5 clk_out = ~clk_out;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit s, input bit p, input bit l, input logic [1:0] t);
        start = s;
        stop  = p;
        loop  = l;
        tempo = t;
    endtask

    function automatic int scaled(input int n, input int t);
        int r;
        case (t)
            1:       r = 2 * n;
            2:       r = (n + 1) / 2;
            default: r = n;
        endcase
        return (r < 1) ? 1 : r;
    endfunction

    task automatic model_reset();
        m_phase  = PH_IDLE;
        m_idx    = 0;
        m_left   = 0;
        m_tempo  = 0;
        m_strobe = 1'b0;
    endtask

    task automatic model_begin(input int idx);
        m_phase  = PH_PLAY;
        m_idx    = idx;
        m_tempo  = TEMPO_EN ? int'(tempo) : 0;
        m_left   = scaled((rom_dur[idx] < 1) ? 1 : rom_dur[idx], m_tempo) * DIV;
        m_strobe = 1'b1;
    endtask

    task automatic model_end_note();
        if (rom_last[m_idx] == 0 && m_idx < 7) model_begin(m_idx + 1);
        else if (loop) model_begin(0);
        else m_phase = PH_DONE;
    endtask

    // Advances the model by one clock edge using the inputs present at that edge
    task automatic model_step();
        m_strobe = 1'b0;
        if (!rst) begin
            model_reset();
            return;
        end
        case (m_phase)
            PH_IDLE: if (start && !stop) model_begin(0);
            PH_PLAY: begin
                if (stop) model_reset();
                else begin
                    m_left--;
                    if (m_left == 0) begin
                        if (GAP_TICKS > 0) begin
                            m_phase = PH_GAP;
                            m_left  = scaled(GAP_TICKS, m_tempo) * DIV;
                        end else model_end_note();
                    end
                end
            end
            PH_GAP: begin
                if (stop) model_reset();
                else begin
                    m_left--;
                    if (m_left == 0) model_end_note();
                end
            end
            default: model_reset();
        endcase
    endtask

    task automatic run_cycle();
        int ef;
        @(posedge clk_out);
        model_step();
        #1;
        ef = (m_phase == PH_PLAY || m_phase == PH_GAP) ? rom_freq[m_idx] : 0;
        checkOutput("busy", busy, m_phase != PH_IDLE);
        checkOutput("freqdiv", freqdiv, ef);
        checkOutput("tone_en", tone_en, (m_phase == PH_PLAY) && (ef != 0));
        checkOutput("note_idx", note_idx, m_idx);
        checkOutput("note_strobe", note_strobe, m_strobe);
        checkOutput("done", done, m_phase == PH_DONE);
        if (note_strobe) cnt_strobe++;
        if (done) cnt_done++;
        if (tone_en && note_idx == 3'd0) cnt_tone0++;
        if (tone_en && note_idx == 3'd7) cnt_tone7++;
    endtask

    task automatic clear_counts();
        cnt_strobe = 0;
        cnt_done   = 0;
        cnt_tone0  = 0;
        cnt_tone7  = 0;
    endtask

    initial begin
        int  hi;
        bit  prev_done;
        rst = 1'b0;
        applyStimulus(0, 0, 0, 2'd0);
        model_reset();
        clear_counts();
        repeat (3) run_cycle();
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_freqdiv", freqdiv, 0);
        rst = 1'b1;
        repeat (2) run_cycle();

        // Scenario 1: first note timing and second strobe
        applyStimulus(1, 0, 0, 2'd0);
        run_cycle();
        checkOutput("s1_strobe", note_strobe, 1);
        checkOutput("s1_idx", note_idx, 0);
        checkOutput("s1_freq", freqdiv, 9555);
        checkOutput("s1_tone", tone_en, 1);
        applyStimulus(0, 0, 0, 2'd0);
        hi = int'(tone_en);
        for (int i = 0; i < 219; i++) begin
            run_cycle();
            hi += int'(tone_en);
        end
        checkOutput("s1_tone_cycles", hi, 200);
        clear_counts();
        run_cycle();
        checkOutput("s1_next_strobe", note_strobe, 1);
        checkOutput("s1_next_idx", note_idx, 1);
        checkOutput("s1_next_freq", freqdiv, 8512);

        // Scenario 2: rest of the song without loop
        prev_done = 1'b0;
        for (int i = 0; i < 1741; i++) begin
            run_cycle();
            if (prev_done) checkOutput("s2_busy_after_done", busy, 0);
            prev_done = done;
        end
        checkOutput("s2_strobes", cnt_strobe + 1, 8);
        checkOutput("s2_done_pulses", cnt_done, 1);
        checkOutput("s2_note7_tone", cnt_tone7, 400);
        checkOutput("s2_idle", busy, 0);

        // Scenario 3: loop restarts at note 0
        clear_counts();
        applyStimulus(1, 0, 1, 2'd0);
        run_cycle();
        applyStimulus(0, 0, 1, 2'd0);
        repeat (1959) run_cycle();
        run_cycle();
        checkOutput("s3_strobe", note_strobe, 1);
        checkOutput("s3_idx", note_idx, 0);
        checkOutput("s3_freq", freqdiv, 9555);
        checkOutput("s3_no_done", cnt_done, 0);
        applyStimulus(0, 1, 0, 2'd0);
        run_cycle();
        applyStimulus(0, 0, 0, 2'd0);
        run_cycle();

        // Scenario 4: stop during note 3
        clear_counts();
        applyStimulus(1, 0, 0, 2'd0);
        run_cycle();
        applyStimulus(0, 0, 0, 2'd0);
        repeat (699) run_cycle();
        checkOutput("s4_in_note3", note_idx, 3);
        applyStimulus(0, 1, 0, 2'd0);
        run_cycle();
        checkOutput("s4_busy", busy, 0);
        checkOutput("s4_tone", tone_en, 0);
        checkOutput("s4_freq", freqdiv, 0);
        checkOutput("s4_idx", note_idx, 0);
        checkOutput("s4_no_done", cnt_done, 0);
        applyStimulus(0, 0, 0, 2'd0);
        repeat (3) run_cycle();

        // Scenario 5: start+stop together, then start mid-note
        applyStimulus(1, 1, 0, 2'd0);
        run_cycle();
        checkOutput("s5_stop_wins", busy, 0);
        applyStimulus(1, 0, 0, 2'd0);
        run_cycle();
        applyStimulus(0, 0, 0, 2'd0);
        repeat (48) run_cycle();
        applyStimulus(1, 0, 0, 2'd0);
        run_cycle();
        applyStimulus(0, 0, 0, 2'd0);
        repeat (171) run_cycle();
        checkOutput("s5_strobe_on_time", note_strobe, 1);
        checkOutput("s5_idx_on_time", note_idx, 1);
        applyStimulus(0, 1, 0, 2'd0);
        run_cycle();
        applyStimulus(0, 0, 0, 2'd0);

        // Scenario 6: asynchronous reset in the gap, then slow-tempo restart
        applyStimulus(1, 0, 0, 2'd0);
        run_cycle();
        applyStimulus(0, 0, 0, 2'd0);
        repeat (204) run_cycle();
        #2;
        rst = 1'b0;
        #1;
        checkOutput("s6_async_busy", busy, 0);
        checkOutput("s6_async_freq", freqdiv, 0);
        checkOutput("s6_async_idx", note_idx, 0);
        model_reset();
        repeat (2) run_cycle();
        rst = 1'b1;
        clear_counts();
        applyStimulus(1, 0, 0, 2'd1);
        run_cycle();
        checkOutput("s6_restart_idx", note_idx, 0);
        checkOutput("s6_restart_strobe", note_strobe, 1);
        applyStimulus(0, 0, 0, 2'd1);
        repeat (450) run_cycle();
        checkOutput("s6_note0_tone", cnt_tone0, TEMPO_EN ? 400 : 200);
        applyStimulus(0, 1, 0, 2'd0);
        run_cycle();

        // Random phase: sparse start/stop, free-running loop and tempo
        for (int i = 0; i < 20000; i++) begin
            applyStimulus(($urandom % 40) == 0, ($urandom % 600) == 0,
                          1'($urandom % 2), 2'($urandom % 4));
            run_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
